// File: rtl/led_sequencer_ctrl.sv
// Running-light LED chase controller driven by one-cycle button pulses (start/pause, direction, stop).
// Optional ping-pong mode: define LED_SEQUENCER_BOUNCE_EN; default build wraps around at the ends.
module led_sequencer_ctrl #(
  parameter int NUM_LEDS    = 3,
  parameter int STEP_CYCLES = 5000000
) (
  input  logic                clock,
  input  logic                reset_s2_n,
  input  logic                start_pressed,
  input  logic                dir_pressed,
  input  logic                stop_pressed,
  output logic [NUM_LEDS-1:0] led,
  output logic                running,
  output logic                step,
  output logic                dir_down
);

  localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                dir_q, dir_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                step_q, step_d;
  logic                running_q, running_d;

  // Position/direction that an advance from the current position would produce.
  logic [POS_W-1:0]    adv_pos;
  logic                adv_dir;

  always_comb begin
    adv_pos = pos_q;
    adv_dir = dir_q;
    if (NUM_LEDS > 1) begin
`ifdef LED_SEQUENCER_BOUNCE_EN
      if (!dir_q) begin
        if (pos_q == POS_LAST) begin
          adv_pos = pos_q - POS_W'(1);
          adv_dir = 1'b1;
        end else begin
          adv_pos = pos_q + POS_W'(1);
        end
      end else begin
        if (pos_q == '0) begin
          adv_pos = POS_W'(1);
          adv_dir = 1'b0;
        end else begin
          adv_pos = pos_q - POS_W'(1);
        end
      end
`else
      if (!dir_q) begin
        adv_pos = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
      end else begin
        adv_pos = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
      end
`endif
    end
  end

  // Priority in every state: stop over start over counting; dir toggles alongside any of them.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    pre_d   = pre_q;
    dir_d   = dir_q ^ dir_pressed;
    step_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!stop_pressed && start_pressed) begin
          state_d = S_RUN;
          pos_d   = '0;
          pre_d   = '0;
        end
      end
      S_RUN: begin
        if (stop_pressed) begin
          state_d = S_IDLE;
          pos_d   = '0;
          pre_d   = '0;
        end else if (start_pressed) begin
          state_d = S_PAUSE;
        end else if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          pos_d  = adv_pos;
          dir_d  = adv_dir ^ dir_pressed;
          step_d = 1'b1;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      S_PAUSE: begin
        if (stop_pressed) begin
          state_d = S_IDLE;
          pos_d   = '0;
          pre_d   = '0;
        end else if (start_pressed) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        pos_d   = '0;
        pre_d   = '0;
      end
    endcase

    led_d = '0;
    if (state_d != S_IDLE) begin
      led_d = NUM_LEDS'(1) << pos_d;
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      pre_q     <= '0;
      dir_q     <= 1'b0;
      led_q     <= '0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      pre_q     <= pre_d;
      dir_q     <= dir_d;
      led_q     <= led_d;
      step_q    <= step_d;
      running_q <= running_d;
    end
  end

  assign led      = led_q;
  assign running  = running_q;
  assign step     = step_q;
  assign dir_down = dir_q;

endmodule
